// File: rtl/reg_write_arbiter_if.sv
// Write bus shared by the SPI peripheral and the local sequencer.
// The SPI side is a fire-and-forget pulse; the sequencer side is valid/ready.
interface reg_write_arbiter_if;
    logic       spi_wr_valid;
    logic [6:0] spi_wr_addr;
    logic [7:0] spi_wr_data;
    logic       seq_wr_valid;
    logic       seq_wr_ready;
    logic [6:0] seq_wr_addr;
    logic [7:0] seq_wr_data;

    // Requesters drive writes and observe the sequencer handshake.
    modport master (
        output spi_wr_valid, spi_wr_addr, spi_wr_data,
        output seq_wr_valid, seq_wr_addr, seq_wr_data,
        input  seq_wr_ready
    );

    // The arbiter consumes writes and answers the sequencer handshake.
    modport slave (
        input  spi_wr_valid, spi_wr_addr, spi_wr_data,
        input  seq_wr_valid, seq_wr_addr, seq_wr_data,
        output seq_wr_ready
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Five-register control bank (output enables, PWM enables, PWM duty) written
// by two requesters: SPI pulses via a 1-deep hold buffer, and a valid/ready
// sequencer. Round-robin arbitration, one commit per cycle, with sticky SPI
// overflow and a saturating count of writes to unmapped addresses.
module reg_write_arbiter #(
    parameter int MAX_ADDR = 4,
    parameter int DROP_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_write_arbiter_if.slave  wr,
    input  logic                clr_status,
    output logic [7:0]          en_reg_out_7_0,
    output logic [7:0]          en_reg_out_15_8,
    output logic [7:0]          en_reg_pwm_7_0,
    output logic [7:0]          en_reg_pwm_15_8,
    output logic [7:0]          pwm_duty_cycle,
    output logic                spi_overflow,
    output logic [DROP_W-1:0]   drop_count,
    output logic                busy
);
    localparam logic [6:0]        MAX_A    = 7'(MAX_ADDR);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    // Which requester wins the next tie.
    typedef enum logic {
        RR_SPI = 1'b0,
        RR_SEQ = 1'b1
    } rr_e;

    rr_e        rr_ptr, rr_ptr_nxt;
    logic       hold_v;
    logic [6:0] hold_addr;
    logic [7:0] hold_data;

    logic       hold_gnt, seq_gnt;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       addr_ok;
    logic       ovf_evt, drop_evt;

    // Grant selection and round-robin pointer update.
    // NOTE: every signal driven here gets a default before any branch, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        hold_gnt   = 1'b0;
        seq_gnt    = 1'b0;
        rr_ptr_nxt = rr_ptr;
        if (hold_v && (!wr.seq_wr_valid || rr_ptr == RR_SPI)) begin
            hold_gnt   = 1'b1;
            rr_ptr_nxt = RR_SEQ;
        end else if (wr.seq_wr_valid) begin
            seq_gnt    = 1'b1;
            rr_ptr_nxt = RR_SPI;
        end
    end

    // The sequencer only sees ready when it wins and the block is out of reset.
    assign wr.seq_wr_ready = seq_gnt & rst_n;

    assign wr_en    = hold_gnt | seq_gnt;
    assign wr_addr  = hold_gnt ? hold_addr : wr.seq_wr_addr;
    assign wr_data  = hold_gnt ? hold_data : wr.seq_wr_data;
    assign addr_ok  = (wr_addr <= MAX_A);
    assign drop_evt = wr_en & ~addr_ok;
    // A held write that loses arbitration is lost when a new pulse lands on it.
    assign ovf_evt  = wr.spi_wr_valid & hold_v & ~hold_gnt;
    assign busy     = hold_v | wr.seq_wr_valid;

    // State register: hold buffer, pointer, register bank and status.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the bank is a handful of control flops driving outputs, so
            // it is reset explicitly rather than treated as uninitialised RAM.
            rr_ptr          <= RR_SPI;
            hold_v          <= 1'b0;
            hold_addr       <= '0;
            hold_data       <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            spi_overflow    <= 1'b0;
            drop_count      <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;

            // A new pulse always wins the buffer; a granted hold empties it.
            if (wr.spi_wr_valid) begin
                hold_v    <= 1'b1;
                hold_addr <= wr.spi_wr_addr;
                hold_data <= wr.spi_wr_data;
            end else if (hold_gnt) begin
                hold_v <= 1'b0;
            end

            if (wr_en && addr_ok) begin
                case (wr_addr)
                    7'h00:   en_reg_out_7_0  <= wr_data;
                    7'h01:   en_reg_out_15_8 <= wr_data;
                    7'h02:   en_reg_pwm_7_0  <= wr_data;
                    7'h03:   en_reg_pwm_15_8 <= wr_data;
                    7'h04:   pwm_duty_cycle  <= wr_data;
                    default: ;
                endcase
            end

            // Clear takes priority over any event in the same cycle.
            if (clr_status) begin
                spi_overflow <= 1'b0;
                drop_count   <= '0;
            end else begin
                if (ovf_evt)
                    spi_overflow <= 1'b1;
                if (drop_evt && drop_count != DROP_MAX)
                    drop_count <= drop_count + DROP_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: a directed vector table, hand-written corner
// sequences and a randomized run checked against a queue-based model.
module tb_reg_write_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr_status;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       spi_overflow;
    logic [7:0] drop_count;
    logic       busy;

    reg_write_arbiter_if bus ();

    reg_write_arbiter #(.MAX_ADDR(4), .DROP_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr              (bus),
        .clr_status      (clr_status),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .spi_overflow    (spi_overflow),
        .drop_count      (drop_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       spi_v;
        logic [6:0] spi_a;
        logic [7:0] spi_d;
        logic       seq_v;
        logic [6:0] seq_a;
        logic [7:0] seq_d;
        logic       clr;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        exp_ready;
        logic        exp_busy;
        logic [48:0] exp_out;
    } vec_t;

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
    } wr_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t st(input logic r, input logic sv, input logic [6:0] sa,
                                 input logic [7:0] sd, input logic qv, input logic [6:0] qa,
                                 input logic [7:0] qd, input logic c);
        stim_t s;
        s = '{rst_n: r, spi_v: sv, spi_a: sa, spi_d: sd, seq_v: qv, seq_a: qa, seq_d: qd, clr: c};
        return s;
    endfunction

    function automatic logic [48:0] outs(input logic [7:0] o0, input logic [7:0] o1,
                                         input logic [7:0] p0, input logic [7:0] p1,
                                         input logic [7:0] d, input logic ovf,
                                         input logic [7:0] drop);
        return {o0, o1, p0, p1, d, ovf, drop};
    endfunction

    function automatic logic [48:0] act_outs();
        return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
                pwm_duty_cycle, spi_overflow, drop_count};
    endfunction

    task automatic apply(input stim_t s);
        rst_n            = s.rst_n;
        bus.spi_wr_valid = s.spi_v;
        bus.spi_wr_addr  = s.spi_a;
        bus.spi_wr_data  = s.spi_d;
        bus.seq_wr_valid = s.seq_v;
        bus.seq_wr_addr  = s.seq_a;
        bus.seq_wr_data  = s.seq_d;
        clr_status       = s.clr;
    endtask

    // ---------------- reference model ----------------
    // Pending SPI writes live in a queue of at most one entry; m_spi_turn says
    // whose turn it is when both sides want the bank.
    wr_t        m_hold[$];
    logic [7:0] m_regs[5];
    bit         m_spi_turn;
    bit         m_ovf;
    int         m_drop;

    function automatic bit m_ready(input stim_t s);
        return s.rst_n && s.seq_v && (m_hold.size() == 0 || !m_spi_turn);
    endfunction

    function automatic logic [48:0] m_outs();
        return outs(m_regs[0], m_regs[1], m_regs[2], m_regs[3], m_regs[4], m_ovf, 8'(m_drop));
    endfunction

    function automatic void m_commit(input wr_t w);
        if (int'(w.a) <= 4) m_regs[int'(w.a)] = w.d;
        else if (m_drop < 255) m_drop++;
    endfunction

    function automatic void model_step(input stim_t s);
        wr_t w;
        bit  spi_wins;
        if (!s.rst_n) begin
            m_hold.delete();
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            m_spi_turn = 1'b1;
            m_ovf      = 1'b0;
            m_drop     = 0;
            return;
        end
        spi_wins = (m_hold.size() > 0) && (!s.seq_v || m_spi_turn);
        if (spi_wins) begin
            m_commit(m_hold.pop_front());
            m_spi_turn = 1'b0;
        end else if (s.seq_v) begin
            w.a = s.seq_a;
            w.d = s.seq_d;
            m_commit(w);
            m_spi_turn = 1'b1;
        end
        if (s.spi_v) begin
            if (m_hold.size() > 0) begin
                m_ovf = 1'b1;
                m_hold.delete();
            end
            w.a = s.spi_a;
            w.d = s.spi_d;
            m_hold.push_back(w);
        end
        if (s.clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endfunction

    // One model-checked cycle; reports whether the sequencer write was taken.
    task automatic mcycle(input stim_t s, output bit accepted);
        bit exp_r, exp_b;
        apply(s);
        exp_r = m_ready(s);
        exp_b = (m_hold.size() > 0) || s.seq_v;
        #1;
        check("seq_wr_ready", 64'(bus.seq_wr_ready), 64'(exp_r));
        check("busy", 64'(busy), 64'(exp_b));
        @(posedge clk);
        model_step(s);
        #1;
        check("bank_status", 64'(act_outs()), 64'(m_outs()));
        accepted = exp_r;
    endtask

    // ---------------- directed vectors ----------------
    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        stim_t s;
        int seq_cnt;

        vecs[0]  = '{st(0,0,7'h00,8'h00,0,7'h00,8'h00,0), 1'b0, 1'b0, outs(8'h00,8'h00,8'h00,8'h00,8'h00,0,8'h00)};
        vecs[1]  = '{st(1,1,7'h04,8'h80,0,7'h00,8'h00,0), 1'b0, 1'b0, outs(8'h00,8'h00,8'h00,8'h00,8'h00,0,8'h00)};
        vecs[2]  = '{st(1,0,7'h00,8'h00,0,7'h00,8'h00,0), 1'b0, 1'b1, outs(8'h00,8'h00,8'h00,8'h00,8'h80,0,8'h00)};
        vecs[3]  = '{st(1,0,7'h00,8'h00,1,7'h02,8'h11,0), 1'b1, 1'b1, outs(8'h00,8'h00,8'h11,8'h00,8'h80,0,8'h00)};
        vecs[4]  = '{st(1,1,7'h01,8'h55,0,7'h00,8'h00,0), 1'b0, 1'b0, outs(8'h00,8'h00,8'h11,8'h00,8'h80,0,8'h00)};
        vecs[5]  = '{st(1,0,7'h00,8'h00,1,7'h00,8'hAA,0), 1'b0, 1'b1, outs(8'h00,8'h55,8'h11,8'h00,8'h80,0,8'h00)};
        vecs[6]  = '{st(1,0,7'h00,8'h00,1,7'h00,8'hAA,0), 1'b1, 1'b1, outs(8'hAA,8'h55,8'h11,8'h00,8'h80,0,8'h00)};
        vecs[7]  = '{st(1,1,7'h03,8'h01,0,7'h00,8'h00,0), 1'b0, 1'b0, outs(8'hAA,8'h55,8'h11,8'h00,8'h80,0,8'h00)};
        vecs[8]  = '{st(1,1,7'h03,8'h02,1,7'h02,8'h22,0), 1'b0, 1'b1, outs(8'hAA,8'h55,8'h11,8'h01,8'h80,0,8'h00)};
        vecs[9]  = '{st(1,1,7'h03,8'h03,1,7'h02,8'h22,0), 1'b1, 1'b1, outs(8'hAA,8'h55,8'h22,8'h01,8'h80,1,8'h00)};
        vecs[10] = '{st(1,0,7'h00,8'h00,0,7'h00,8'h00,0), 1'b0, 1'b1, outs(8'hAA,8'h55,8'h22,8'h03,8'h80,1,8'h00)};
        vecs[11] = '{st(1,0,7'h00,8'h00,1,7'h05,8'hFF,0), 1'b1, 1'b1, outs(8'hAA,8'h55,8'h22,8'h03,8'h80,1,8'h01)};
        vecs[12] = '{st(1,0,7'h00,8'h00,1,7'h7F,8'hFF,1), 1'b1, 1'b1, outs(8'hAA,8'h55,8'h22,8'h03,8'h80,0,8'h00)};
        vecs[13] = '{st(1,0,7'h00,8'h00,1,7'h06,8'h01,0), 1'b1, 1'b1, outs(8'hAA,8'h55,8'h22,8'h03,8'h80,0,8'h01)};
        vecs[14] = '{st(1,1,7'h02,8'h3C,0,7'h00,8'h00,0), 1'b0, 1'b0, outs(8'hAA,8'h55,8'h22,8'h03,8'h80,0,8'h01)};
        vecs[15] = '{st(0,0,7'h00,8'h00,1,7'h00,8'h77,0), 1'b0, 1'b1, outs(8'h00,8'h00,8'h00,8'h00,8'h00,0,8'h00)};
        vecs[16] = '{st(1,0,7'h00,8'h00,1,7'h00,8'h77,0), 1'b1, 1'b1, outs(8'h77,8'h00,8'h00,8'h00,8'h00,0,8'h00)};
        vecs[17] = '{st(1,0,7'h00,8'h00,0,7'h00,8'h00,0), 1'b0, 1'b0, outs(8'h77,8'h00,8'h00,8'h00,8'h00,0,8'h00)};

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].s);
            #1;
            check($sformatf("vec%0d_ready", i), 64'(bus.seq_wr_ready), 64'(vecs[i].exp_ready));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_outs", i), 64'(act_outs()), 64'(vecs[i].exp_out));
        end

        // Drop counter saturation: 5 writes to 0x05 then 300 to 0x7F.
        mcycle(st(0,0,7'h00,8'h00,0,7'h00,8'h00,0), acc);
        for (int i = 0; i < 5; i++)
            mcycle(st(1,0,7'h00,8'h00,1,7'h05,8'(i),0), acc);
        for (int i = 0; i < 300; i++)
            mcycle(st(1,0,7'h00,8'h00,1,7'h7F,8'(i),0), acc);
        check("drop_saturated", 64'(drop_count), 64'h00FF);
        check("regs_untouched_by_drops", 64'(act_outs()), 64'(outs(8'h00,8'h00,8'h00,8'h00,8'h00,0,8'hFF)));
        mcycle(st(1,0,7'h00,8'h00,0,7'h00,8'h00,1), acc);
        check("drop_cleared", 64'(drop_count), 64'h0);
        check("ovf_cleared", 64'(spi_overflow), 64'h0);

        // Continuous sequencer traffic with SPI pulses every other cycle.
        mcycle(st(0,0,7'h00,8'h00,0,7'h00,8'h00,0), acc);
        seq_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            s = st(1, (i % 2) == 0, 7'(i % 5), 8'(8'h40 + i),
                   1, 7'(seq_cnt % 5), 8'(8'hC0 + seq_cnt), 0);
            mcycle(s, acc);
            if (acc) seq_cnt++;
        end
        check("alternate_no_overflow", 64'(spi_overflow), 64'h0);
        check("alternate_seq_progress", 64'(seq_cnt), 64'd20);

        // Randomized traffic against the model.
        mcycle(st(0,0,7'h00,8'h00,0,7'h00,8'h00,0), acc);
        s = st(1,0,7'h00,8'h00,0,7'h00,8'h00,0);
        for (int i = 0; i < 400; i++) begin
            s.rst_n = ($urandom_range(0, 99) != 0);
            s.spi_v = ($urandom_range(0, 2) == 0);
            s.spi_a = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 6));
            s.spi_d = 8'($urandom);
            if (!s.seq_v && $urandom_range(0, 1) == 1) begin
                s.seq_v = 1'b1;
                s.seq_a = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 6));
                s.seq_d = 8'($urandom);
            end
            s.clr = ($urandom_range(0, 19) == 0);
            mcycle(s, acc);
            if (acc) s.seq_v = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
